pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Central pipeline controller for the 5-stage core. Collapses per-stage stall requests into the
//  stalled[4:0] vector consumed by pc/if_id/id_ex/ex_mem/mem_wb, and issues branch and trap
//  redirects with flushes. Sequences trap entry with a drain/flush FSM.
//  Keeps a saturating stall-cycle counter and a consecutive-stall watchdog.
// PARAMETERS
//  ADDR_W   32    width of redirect PC / vectors
//  CNT_W    32    width of stall_cnt_o (saturating)
//  TIMEOUT  1024  consecutive stalled cycles before timeout_o sets (>=1)
// PORTS
//  clk             in   1       clock
//  rst             in   1       reset, asynchronous, active-low
//  stallreq_if_i   in   1       fetch bus wait
//  stallreq_id_i   in   1       load-use hazard
//  stallreq_ex_i   in   1       multi-cycle ALU (div) busy
//  stallreq_mem_i  in   1       data bus wait
//  branch_flag_i   in   1       taken branch/jump resolved in ex
//  branch_addr_i   in   ADDR_W  branch target
//  trap_req_i      in   1       exception/interrupt at mem; held until trap_ack_o
//  trap_vec_i      in   ADDR_W  trap handler address
//  stalled_o       out  5       bit0 pc, 1 if, 2 id, 3 ex, 4 mem; 1 = Stop
//  flush_ifid_o    out  1       kill if_id and id_ex contents (branch)
//  flush_o         out  1       kill all pipeline registers (trap)
//  new_pc_o        out  ADDR_W  redirect target
//  new_pc_valid_o  out  1       pc loads new_pc_o this cycle
//  trap_ack_o      out  1       one-cycle trap-taken pulse
//  stall_cnt_o     out  CNT_W   total stalled cycles, saturating
//  timeout_o       out  1       sticky watchdog flag
// BEHAVIOUR
//  Reset (rst low, async): state RUN; all outputs 0; counters 0; latched vector 0.
//  States: RUN, DRAIN, FLUSH (2-bit, registered). Outputs combinational from state + inputs.
//  RUN stall priority, highest first, same-cycle (0 latency):
//   mem -> 5'b11111; ex -> 5'b01111; id -> 5'b00111; if -> 5'b00011; none -> 5'b00000.
//   Stage k stopped with k+1 running makes the k/k+1 register insert a bubble.
//  Branch (RUN): branch_flag_i & !stallreq_ex_i & !stallreq_mem_i & !trap_req_i ->
//   flush_ifid_o=1, new_pc_valid_o=1, new_pc_o=branch_addr_i, same cycle. Branch under
//   ex/mem stall is ignored; ex re-presents it after release. Branch with if/id stall wins:
//   flush overrides stall, stalled_o=0.
//  Trap: RUN & trap_req_i: stalled_o=5'b11111, latch trap_vec_i.
//   stallreq_mem_i=1 -> DRAIN, else -> FLUSH.
//   DRAIN: stalled_o=5'b11111; stay while stallreq_mem_i; -> FLUSH when it drops.
//   FLUSH (exactly 1 cycle): flush_o=1, new_pc_valid_o=1, new_pc_o=latched vector,
//   trap_ack_o=1, stalled_o=0 -> RUN.
//   Branch and lower-stage stall requests are ignored in DRAIN/FLUSH.
//   trap_req_i still high in the cycle after ack is a new trap.
//  stall_cnt_o: +1 each cycle stalled_o!=0; holds at all-ones.
//  Watchdog: consecutive counter ($clog2(TIMEOUT+1) bits) +1 while stalled_o!=0, cleared when
//   stalled_o==0. On reaching TIMEOUT, timeout_o sets and stays set until reset.
//  Reset mid-DRAIN/FLUSH: abort to RUN, no ack issued.
// STRUCTURE
//  yadan_defs.v: Stop/NoStop, RstEnable, stall masks STALL_IF/ID/EX/MEM, state encodings
//   CTRL_RUN/DRAIN/FLUSH.
//  Sub-module stall_watchdog (consecutive counter + sticky flag + saturating total counter),
//   fed stall_any; FSM and priority mux stay in pipe_ctrl.
// TESTING
//  1. stallreq_ex_i=1 for 3 cycles, others 0 -> stalled_o=01111 those cycles, stall_cnt_o +3.
//  2. stallreq_id_i & stallreq_mem_i same cycle -> stalled_o=11111; drop mem -> 00111.
//  3. branch_flag_i, addr 0x8000_0040, no stall -> same cycle flush_ifid_o=1,
//     new_pc_valid_o=1, new_pc_o=0x8000_0040; repeat with stallreq_ex_i=1 -> no redirect.
//  4. trap_req_i, vec 0x100, stallreq_mem_i high 4 cycles -> 11111 for 5 cycles, then one
//     FLUSH cycle: flush_o, trap_ack_o, new_pc_o=0x100; then RUN.
//  5. TIMEOUT=8, stallreq_if_i held 8 cycles -> timeout_o rises after the 8th; stays high
//     after release.
//  6. rst low during DRAIN -> all outputs 0 immediately; no trap_ack_o after release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stop levels, stall masks,
// controller state encodings and the stall-priority helper.
package pipe_ctrl_pkg;

  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;
  localparam logic RST_ENABLE = 1'b0;

  // One bit per stage: bit0 pc, 1 if, 2 id, 3 ex, 4 mem. A requesting stage
  // stops itself and everything upstream of it.
  localparam logic [4:0] STALL_NONE = {5{NO_STOP}};
  localparam logic [4:0] STALL_IF   = 5'b00011;
  localparam logic [4:0] STALL_ID   = 5'b00111;
  localparam logic [4:0] STALL_EX   = 5'b01111;
  localparam logic [4:0] STALL_MEM  = {5{STOP}};

  typedef enum logic [1:0] {
    CTRL_RUN   = 2'd0,
    CTRL_DRAIN = 2'd1,
    CTRL_FLUSH = 2'd2
  } ctrl_state_t;

  // Deepest requesting stage wins.
  function automatic logic [4:0] stall_mask(input logic req_if, input logic req_id,
                                            input logic req_ex, input logic req_mem);
    logic [4:0] m;
    m = STALL_NONE;
    if (req_mem)     m = STALL_MEM;
    else if (req_ex) m = STALL_EX;
    else if (req_id) m = STALL_ID;
    else if (req_if) m = STALL_IF;
    return m;
  endfunction

endpackage

// File: rtl/pipe_ctrl_watchdog.sv
// Stall bookkeeping: saturating total stalled-cycle counter plus a
// consecutive-stall counter that sets a sticky timeout flag.
module pipe_ctrl_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_any,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             timeout
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] consec_q;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      stall_cnt <= '0;
      consec_q  <= '0;
      timeout   <= 1'b0;
    end else begin
      if (stall_any && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;

      // The run length parks at TIMEOUT so it can never wrap back to zero.
      if (!stall_any)
        consec_q <= '0;
      else if (consec_q != WD_LIMIT)
        consec_q <= consec_q + 1'b1;

      if (stall_any && (consec_q == WD_LAST))
        timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall priority mux, branch redirect and the
// RUN/DRAIN/FLUSH trap-entry sequencer, with stall statistics.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if_i,
  input  logic              stallreq_id_i,
  input  logic              stallreq_ex_i,
  input  logic              stallreq_mem_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  input  logic              trap_req_i,
  input  logic [ADDR_W-1:0] trap_vec_i,
  output logic [4:0]        stalled_o,
  output logic              flush_ifid_o,
  output logic              flush_o,
  output logic [ADDR_W-1:0] new_pc_o,
  output logic              new_pc_valid_o,
  output logic              trap_ack_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic              timeout_o,
  output logic [1:0]        state_o
);

  // Trap handshake: trap_req_i is a level request held by the requester until
  // it sees trap_ack_o, a single-cycle pulse issued in the FLUSH cycle. A
  // request still high in the cycle after the ack is taken as a new trap.

  ctrl_state_t       state_q;
  logic [ADDR_W-1:0] vec_q;
  logic              branch_ok;
  logic              stall_any;

  logic [4:0]        stalled_c;
  logic              flush_ifid_c;
  logic              flush_c;
  logic              new_pc_valid_c;
  logic              trap_ack_c;
  logic [ADDR_W-1:0] new_pc_c;

  // A branch is only honoured when ex/mem can move; otherwise ex re-presents it.
  assign branch_ok = branch_flag_i & ~stallreq_ex_i & ~stallreq_mem_i & ~trap_req_i;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q <= CTRL_RUN;
      vec_q   <= '0;
    end else begin
      case (state_q)
        CTRL_RUN: begin
          if (trap_req_i) begin
            vec_q   <= trap_vec_i;
            state_q <= stallreq_mem_i ? CTRL_DRAIN : CTRL_FLUSH;
          end
        end
        CTRL_DRAIN: begin
          if (!stallreq_mem_i)
            state_q <= CTRL_FLUSH;
        end
        CTRL_FLUSH: state_q <= CTRL_RUN;
        default:    state_q <= CTRL_RUN;
      endcase
    end
  end

  always_comb begin
    stalled_c      = STALL_NONE;
    flush_ifid_c   = 1'b0;
    flush_c        = 1'b0;
    new_pc_valid_c = 1'b0;
    trap_ack_c     = 1'b0;
    new_pc_c       = '0;
    case (state_q)
      CTRL_RUN: begin
        if (trap_req_i) begin
          stalled_c = STALL_MEM;
        end else if (branch_ok) begin
          // Flush overrides any if/id stall so the wrong-path fetch is dropped.
          flush_ifid_c   = 1'b1;
          new_pc_valid_c = 1'b1;
          new_pc_c       = branch_addr_i;
        end else begin
          stalled_c = stall_mask(stallreq_if_i, stallreq_id_i,
                                 stallreq_ex_i, stallreq_mem_i);
        end
      end
      CTRL_DRAIN: stalled_c = STALL_MEM;
      CTRL_FLUSH: begin
        flush_c        = 1'b1;
        new_pc_valid_c = 1'b1;
        new_pc_c       = vec_q;
        trap_ack_c     = 1'b1;
      end
      default: stalled_c = STALL_NONE;
    endcase
  end

  // Outputs are forced quiet while reset is held, regardless of the requests.
  assign stalled_o      = rst ? stalled_c      : STALL_NONE;
  assign flush_ifid_o   = rst ? flush_ifid_c   : 1'b0;
  assign flush_o        = rst ? flush_c        : 1'b0;
  assign new_pc_valid_o = rst ? new_pc_valid_c : 1'b0;
  assign trap_ack_o     = rst ? trap_ack_c     : 1'b0;
  assign new_pc_o       = rst ? new_pc_c       : '0;
  assign state_o        = state_q;

  assign stall_any = |stalled_o;

  pipe_ctrl_watchdog #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .stall_any (stall_any),
    .stall_cnt (stall_cnt_o),
    .timeout   (timeout_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, branch redirect, trap
// drain/flush, watchdog and reset abort, with a redirect-target scoreboard.
module tb_pipe_ctrl;

  localparam int ADDR_W  = 32;
  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 8;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic              clk;
  logic              rst;
  logic              stallreq_if_i;
  logic              stallreq_id_i;
  logic              stallreq_ex_i;
  logic              stallreq_mem_i;
  logic              branch_flag_i;
  logic [ADDR_W-1:0] branch_addr_i;
  logic              trap_req_i;
  logic [ADDR_W-1:0] trap_vec_i;
  logic [4:0]        stalled_o;
  logic              flush_ifid_o;
  logic              flush_o;
  logic [ADDR_W-1:0] new_pc_o;
  logic              new_pc_valid_o;
  logic              trap_ack_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic              timeout_o;
  logic [1:0]        state_o;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;
  logic [ADDR_W-1:0] exp_q[$];

  pipe_ctrl #(
    .ADDR_W  (ADDR_W),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_if_i  (stallreq_if_i),
    .stallreq_id_i  (stallreq_id_i),
    .stallreq_ex_i  (stallreq_ex_i),
    .stallreq_mem_i (stallreq_mem_i),
    .branch_flag_i  (branch_flag_i),
    .branch_addr_i  (branch_addr_i),
    .trap_req_i     (trap_req_i),
    .trap_vec_i     (trap_vec_i),
    .stalled_o      (stalled_o),
    .flush_ifid_o   (flush_ifid_o),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o),
    .new_pc_valid_o (new_pc_valid_o),
    .trap_ack_o     (trap_ack_o),
    .stall_cnt_o    (stall_cnt_o),
    .timeout_o      (timeout_o),
    .state_o        (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_stall(input logic s_if, input logic s_id, input logic s_ex, input logic s_mem);
    stallreq_if_i  = s_if;
    stallreq_id_i  = s_id;
    stallreq_ex_i  = s_ex;
    stallreq_mem_i = s_mem;
  endtask

  // scoreboard: every redirect must match the next expected target
  always @(negedge clk) begin
    if (rst && new_pc_valid_o) begin
      if (exp_q.size() == 0) check("unexpected_redirect", 64'(new_pc_o), 64'hDEAD);
      else check("redirect_target", 64'(new_pc_o), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    rst = 1'b0;
    set_stall(1'b0, 1'b0, 1'b0, 1'b0);
    branch_flag_i = 1'b0;
    branch_addr_i = '0;
    trap_req_i    = 1'b0;
    trap_vec_i    = '0;

    // reset state, with a stall request applied while reset is held
    #3;
    stallreq_mem_i = 1'b1;
    #1;
    check("rst_stalled", 64'(stalled_o), 64'h0);
    check("rst_cnt", 64'(stall_cnt_o), 64'h0);
    check("rst_timeout", 64'(timeout_o), 64'h0);
    check("rst_state", 64'(state_o), 64'(S_RUN));
    stallreq_mem_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();

    // 1: ex stall for 3 cycles
    set_stall(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ex_stalled", 64'(stalled_o), 64'b01111);
      check("ex_cnt", 64'(stall_cnt_o), 64'(exp_cnt));
      tick();
      exp_cnt++;
    end
    set_stall(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("ex_release", 64'(stalled_o), 64'h0);
    check("ex_cnt_final", 64'(stall_cnt_o), 64'd3);

    // 2: id + mem together, then id alone, then if alone
    tick();
    set_stall(1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    check("idmem_stalled", 64'(stalled_o), 64'b11111);
    tick(); exp_cnt++;
    stallreq_mem_i = 1'b0;
    #1;
    check("id_stalled", 64'(stalled_o), 64'b00111);
    tick(); exp_cnt++;
    set_stall(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("if_stalled", 64'(stalled_o), 64'b00011);
    tick(); exp_cnt++;
    set_stall(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("cnt_after_2", 64'(stall_cnt_o), 64'd6);

    // 3: branch redirect, branch under ex stall, branch beating an id stall
    tick();
    branch_flag_i = 1'b1;
    branch_addr_i = 32'h8000_0040;
    exp_q.push_back(32'h8000_0040);
    #1;
    check("br_flush_ifid", 64'(flush_ifid_o), 64'd1);
    check("br_valid", 64'(new_pc_valid_o), 64'd1);
    check("br_pc", 64'(new_pc_o), 64'h8000_0040);
    check("br_stalled", 64'(stalled_o), 64'h0);
    check("br_flush", 64'(flush_o), 64'd0);
    tick();
    stallreq_ex_i = 1'b1;
    #1;
    check("br_ex_flush_ifid", 64'(flush_ifid_o), 64'd0);
    check("br_ex_valid", 64'(new_pc_valid_o), 64'd0);
    check("br_ex_stalled", 64'(stalled_o), 64'b01111);
    tick(); exp_cnt++;
    set_stall(1'b0, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(32'h8000_0040);
    #1;
    check("br_id_stalled", 64'(stalled_o), 64'h0);
    check("br_id_flush_ifid", 64'(flush_ifid_o), 64'd1);
    tick();
    set_stall(1'b0, 1'b0, 1'b0, 1'b0);
    branch_flag_i = 1'b0;
    #1;
    check("cnt_after_3", 64'(stall_cnt_o), 64'd7);

    // 4: trap with mem busy for 4 cycles; a branch during drain is ignored
    tick();
    trap_req_i     = 1'b1;
    trap_vec_i     = 32'h0000_0100;
    stallreq_mem_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        branch_flag_i = 1'b1;
        trap_vec_i    = 32'h0000_0bad;
      end
      if (i == 4) stallreq_mem_i = 1'b0;
      #1;
      check("trap_stalled", 64'(stalled_o), 64'b11111);
      check("trap_no_ack", 64'(trap_ack_o), 64'd0);
      check("trap_no_brflush", 64'(flush_ifid_o), 64'd0);
      check("trap_state", 64'(state_o), (i == 0) ? 64'(S_RUN) : 64'(S_DRAIN));
      tick();
      exp_cnt++;
    end
    exp_q.push_back(32'h0000_0100);
    #1;
    check("flush_state", 64'(state_o), 64'(S_FLUSH));
    check("flush_flush", 64'(flush_o), 64'd1);
    check("flush_ack", 64'(trap_ack_o), 64'd1);
    check("flush_valid", 64'(new_pc_valid_o), 64'd1);
    check("flush_pc", 64'(new_pc_o), 64'h100);
    check("flush_stalled", 64'(stalled_o), 64'h0);
    tick();
    trap_req_i    = 1'b0;
    branch_flag_i = 1'b0;
    #1;
    check("post_trap_state", 64'(state_o), 64'(S_RUN));
    check("post_trap_ack", 64'(trap_ack_o), 64'd0);
    check("cnt_after_4", 64'(stall_cnt_o), 64'd12);

    // 5: watchdog with TIMEOUT=8
    tick();
    stallreq_if_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("wd_before", 64'(timeout_o), 64'd0);
      tick();
      exp_cnt++;
    end
    #1;
    check("wd_set", 64'(timeout_o), 64'd1);
    stallreq_if_i = 1'b0;
    tick();
    #1;
    check("wd_sticky", 64'(timeout_o), 64'd1);
    check("cnt_after_5", 64'(stall_cnt_o), 64'(exp_cnt));

    // 6: reset in DRAIN aborts the trap with no ack
    trap_req_i     = 1'b1;
    trap_vec_i     = 32'h0000_0200;
    stallreq_mem_i = 1'b1;
    tick();
    #1;
    check("abort_in_drain", 64'(state_o), 64'(S_DRAIN));
    rst = 1'b0;
    #1;
    check("abort_stalled", 64'(stalled_o), 64'h0);
    check("abort_flush", 64'(flush_o), 64'd0);
    check("abort_ack", 64'(trap_ack_o), 64'd0);
    check("abort_valid", 64'(new_pc_valid_o), 64'd0);
    check("abort_cnt", 64'(stall_cnt_o), 64'h0);
    check("abort_timeout", 64'(timeout_o), 64'd0);
    check("abort_state", 64'(state_o), 64'(S_RUN));
    trap_req_i     = 1'b0;
    stallreq_mem_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_abort_ack", 64'(trap_ack_o), 64'd0);
      check("post_abort_flush", 64'(flush_o), 64'd0);
    end

    // final report
    check("redirects_pending", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
